// File: rtl/polar_peak_detect.sv
// polar_peak_detect: per-window peak, angle, index and mean of the CORDIC magnitude stream,
// with a valid delay line matched to the processor pipeline and a valid/ready result port.
module polar_peak_detect #(
    parameter int LATENCY = 17,
    parameter int WINDOW  = 64,
    parameter int IW      = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          in_valid,
    input  logic [19:0]   rin,
    input  logic [15:0]   ain,
    input  logic          res_ready,
    output logic          res_valid,
    output logic [19:0]   res_peak,
    output logic [15:0]   res_ang,
    output logic [IW-1:0] res_idx,
    output logic [19:0]   res_mean,
    output logic          overrun,
    input  logic          ovr_clr
);
    localparam int SW = 20 + IW;

    logic [LATENCY-1:0] vpipe_q, vpipe_d;
    logic [IW-1:0]      cnt_q, cnt_d, pidx_q, pidx_d, ridx_q, ridx_d;
    logic [19:0]        peak_q, peak_d, rpeak_q, rpeak_d, rmean_q, rmean_d;
    logic [15:0]        pang_q, pang_d, rang_q, rang_d;
    logic [SW-1:0]      sum_q, sum_d;
    logic               rvalid_q, rvalid_d, ovr_q, ovr_d;
    logic               q, first, take, close, free;

    always_comb begin
        vpipe_d  = ena ? LATENCY'({vpipe_q, in_valid}) : vpipe_q;
        q        = ena & vpipe_q[LATENCY-1];
        first    = cnt_q == '0;
        take     = first | (rin > peak_q);
        close    = q & (cnt_q == IW'(WINDOW - 1));
        free     = ~rvalid_q | res_ready;
        peak_d   = (q & take) ? rin : peak_q;
        pang_d   = (q & take) ? ain : pang_q;
        pidx_d   = (q & take) ? cnt_q : pidx_q;
        sum_d    = q ? (first ? SW'(rin) : sum_q + SW'(rin)) : sum_q;
        cnt_d    = q ? cnt_q + IW'(1) : cnt_q;
        // The closing sample's contribution is taken from the _d values, not the registers
        rpeak_d  = (close & free) ? peak_d : rpeak_q;
        rang_d   = (close & free) ? pang_d : rang_q;
        ridx_d   = (close & free) ? pidx_d : ridx_q;
        rmean_d  = (close & free) ? sum_d[SW-1:IW] : rmean_q;
        rvalid_d = (close & free) ? 1'b1 : (rvalid_q & res_ready) ? 1'b0 : rvalid_q;
        ovr_d    = (close & ~free) ? 1'b1 : ovr_clr ? 1'b0 : ovr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_q  <= '0;
            cnt_q    <= '0;
            peak_q   <= '0;
            pang_q   <= '0;
            pidx_q   <= '0;
            sum_q    <= '0;
            rpeak_q  <= '0;
            rang_q   <= '0;
            ridx_q   <= '0;
            rmean_q  <= '0;
            rvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            vpipe_q  <= vpipe_d;
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            pang_q   <= pang_d;
            pidx_q   <= pidx_d;
            sum_q    <= sum_d;
            rpeak_q  <= rpeak_d;
            rang_q   <= rang_d;
            ridx_q   <= ridx_d;
            rmean_q  <= rmean_d;
            rvalid_q <= rvalid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign res_valid = rvalid_q;
    assign res_peak  = rpeak_q;
    assign res_ang   = rang_q;
    assign res_idx   = ridx_q;
    assign res_mean  = rmean_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_polar_peak_detect.sv
// tb_polar_peak_detect: table-driven windows, directed corner sequences and a randomized
// run, all checked against a queue-based reference model of the window statistics.
module tb_polar_peak_detect;
    localparam int LAT = 17, W = 4, IW = 2;

    logic clk = 0, rst = 1, ena = 0, in_valid = 0, res_ready = 0, ovr_clr = 0;
    logic [19:0] rin = 0;
    logic [15:0] ain = 0;
    logic res_valid, overrun;
    logic [19:0] res_peak, res_mean;
    logic [15:0] res_ang;
    logic [IW-1:0] res_idx;

    polar_peak_detect #(.LATENCY(LAT), .WINDOW(W), .IW(IW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .rin(rin), .ain(ain),
        .res_ready(res_ready), .res_valid(res_valid), .res_peak(res_peak), .res_ang(res_ang),
        .res_idx(res_idx), .res_mean(res_mean), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    typedef struct {logic [19:0] r; logic [15:0] a;} samp_t;
    typedef struct {logic [19:0] r0, r1, r2, r3, peak, mean; int idx; int stall;} rec_t;

    samp_t feed[$], pend[$], win[$];
    bit hist[$];
    logic m_valid = 0, m_ovr = 0;
    logic [19:0] m_peak = 0, m_mean = 0;
    logic [15:0] m_ang = 0;
    logic [IW-1:0] m_idx = 0;
    int checks = 0, errors = 0;
    bit ready_on_close = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic samp_t rnd_samp();
        samp_t s;
        s.r = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 3)) : 20'($urandom);
        s.a = 16'($urandom);
        return s;
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    task automatic tick(input logic en, input logic iv, input logic rdy, input logic clr);
        bit qp, closed, free;
        samp_t s;
        logic rd;
        longint sum;
        qp = en && hist.size() == LAT && hist[0];
        rd = rdy | (ready_on_close && qp && win.size() == W - 1);
        s = (qp && !rst && pend.size() > 0) ? pend.pop_front() : rnd_samp();
        ena = en; in_valid = iv; res_ready = rd; ovr_clr = clr; rin = s.r; ain = s.a;
        @(posedge clk);
        if (rst) begin
            hist.delete(); pend.delete(); win.delete();
            m_valid = 0; m_ovr = 0; m_peak = 0; m_mean = 0; m_ang = 0; m_idx = 0;
        end else begin
            closed = 0;
            free = !m_valid || rd;
            if (qp) begin
                win.push_back(s);
                closed = win.size() == W;
            end
            if (closed && free) begin
                m_peak = win[0].r; m_ang = win[0].a; m_idx = 0; sum = 0;
                for (int i = 0; i < W; i++) begin
                    sum += win[i].r;
                    if (win[i].r > m_peak) begin m_peak = win[i].r; m_ang = win[i].a; m_idx = IW'(i); end
                end
                m_mean = 20'(sum / W);
                m_valid = 1;
            end else if (m_valid && rd) m_valid = 0;
            m_ovr = (closed && !free) ? 1'b1 : clr ? 1'b0 : m_ovr;
            if (closed) win.delete();
            if (en) begin
                if (iv) pend.push_back(feed.size() > 0 ? feed.pop_front() : rnd_samp());
                hist.push_back(iv);
                if (hist.size() > LAT) void'(hist.pop_front());
            end
        end
        #1;
        chk("res_valid", res_valid, m_valid);
        chk("overrun", overrun, m_ovr);
        if (m_valid) begin
            chk("res_peak", res_peak, m_peak);
            chk("res_ang", res_ang, m_ang);
            chk("res_idx", res_idx, m_idx);
            chk("res_mean", res_mean, m_mean);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        tick(0, 0, 0, 0);
        rst = 0;
    endtask

    task automatic run_win(input rec_t t, input bit check_tbl);
        logic [19:0] v[4];
        int n;
        v[0] = t.r0; v[1] = t.r1; v[2] = t.r2; v[3] = t.r3;
        for (int i = 0; i < W; i++) feed.push_back('{r: v[i], a: 16'h1000 + 16'(i)});
        for (int i = 0; i < W; i++) begin
            if (i == t.stall) repeat (5) tick(0, 1, 0, 0);
            tick(1, 1, 0, 0);
        end
        n = 0;
        while (pend.size() > 0 && n < 40) begin tick(1, 0, 0, 0); n++; end
        chk("drain_timeout", 32'(n < 40), 1);
        if (check_tbl) begin
            chk("tbl_peak", res_peak, t.peak);
            chk("tbl_idx", res_idx, 32'(t.idx));
            chk("tbl_mean", res_mean, t.mean);
            chk("tbl_ang", res_ang, 32'(16'h1000 + t.idx));
        end
    endtask

    rec_t tbl[6];

    initial begin
        tbl[0] = '{r0: 100, r1: 300, r2: 200, r3: 50, peak: 300, mean: 162, idx: 1, stall: 99};
        tbl[1] = '{r0: 500, r1: 500, r2: 10, r3: 10, peak: 500, mean: 255, idx: 0, stall: 2};
        tbl[2] = '{r0: 7, r1: 8, r2: 9, r3: 6, peak: 9, mean: 7, idx: 2, stall: 99};
        tbl[3] = '{r0: 0, r1: 0, r2: 0, r3: 0, peak: 0, mean: 0, idx: 0, stall: 1};
        tbl[4] = '{r0: 20'hFFFFF, r1: 20'hFFFFF, r2: 20'hFFFFF, r3: 20'hFFFFF,
                   peak: 20'hFFFFF, mean: 20'hFFFFF, idx: 0, stall: 99};
        tbl[5] = '{r0: 1, r1: 2, r2: 3, r3: 4, peak: 4, mean: 2, idx: 3, stall: 3};

        do_reset();
        chk("rst_valid", res_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_peak", res_peak, 0);
        chk("rst_ang", res_ang, 0);
        chk("rst_idx", res_idx, 0);
        chk("rst_mean", res_mean, 0);

        foreach (tbl[k]) begin
            run_win(tbl[k], 1);
            repeat (3) tick(1, 0, 0, 0);
            chk("hold_peak", res_peak, tbl[k].peak);
            tick(1, 0, 1, 0);
            chk("accept_valid", res_valid, 0);
        end

        run_win(tbl[0], 1);
        run_win(tbl[5], 0);
        chk("ovr_set", overrun, 1);
        chk("ovr_keep_peak", res_peak, tbl[0].peak);
        chk("ovr_keep_idx", res_idx, 32'(tbl[0].idx));
        tick(1, 0, 0, 1);
        chk("ovr_clr", overrun, 0);
        chk("ovr_clr_peak", res_peak, tbl[0].peak);

        ready_on_close = 1;
        run_win(tbl[2], 1);
        ready_on_close = 0;
        chk("simul_valid", res_valid, 1);
        chk("simul_ovr", overrun, 0);
        tick(1, 0, 1, 0);

        for (int i = 0; i < W; i++) tick(1, 1, 0, 0);
        for (int n = 0; n < 40 && win.size() < 2; n++) tick(1, 0, 0, 0);
        chk("midwin_reached", 32'(win.size()), 2);
        do_reset();
        chk("midrst_valid", res_valid, 0);
        run_win(tbl[2], 1);
        tick(1, 0, 1, 0);

        for (int c = 0; c < 400; c++)
            tick($urandom_range(0, 9) != 0, c % 3 == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0);
        for (int c = 0; c < 60; c++) tick(1, 0, $urandom_range(0, 1) == 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/polar_peak_detect.md
Name: polar_peak_detect

Overview:
- Sits directly downstream of the rectangular-to-polar CORDIC processor and consumes its magnitude (rout, 20 b) and angle (aout, 16 b) outputs.
- The processor carries no valid flag, so this block tracks sample validity with its own delay line, matched to the processor's pipeline latency.
- Over fixed windows of WINDOW valid samples it finds the peak magnitude, its angle and its index, and computes the mean magnitude.
- Each window's result is presented on a valid/ready output port.

Parameters:
- LATENCY, 17, cycles (ena-qualified) from processor input to rout/aout.
- WINDOW, 64, samples per window; power of two, 2 or more.
- IW, 6, index width = log2(WINDOW).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ena  in  1  pipeline enable, the same signal that drives the processor.
- in_valid  in  1  a valid sample is applied to processor xin/yin this cycle.
- rin  in  20  magnitude from processor (unsigned).
- ain  in  16  angle from processor.
- res_ready  in  1  downstream accepts the result.
- res_valid  out  1  result registers hold an unconsumed result.
- res_peak  out  20  peak magnitude of the window.
- res_ang  out  16  angle at the peak.
- res_idx  out  IW  sample index of the peak (0 = first sample).
- res_mean  out  20  sum of magnitudes >> IW (truncating).
- overrun  out  1  sticky; set when a window result is dropped.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset (rst=1 at a clk edge): valid delay line, cnt, peak/sum accumulators, res_valid, all res_* outputs and overrun go to 0. A partially accumulated window is discarded.
- Valid delay line:
  - LATENCY-bit shift register vpipe, shifting only when ena=1; vpipe[0] <= in_valid.
  - When ena=0 the line holds and in_valid is ignored, which mirrors the processor stall.
- Qualified sample: q = ena & vpipe[LATENCY-1]. rin/ain are sampled only on q.
- Accumulation on q:
  - If cnt==0 or rin > peak (strict unsigned compare): peak<=rin, pang<=ain, pidx<=cnt. Ties keep the earlier sample.
  - sum: if cnt==0, sum<=rin; otherwise sum<=sum+rin. sum width is 20+IW and cannot overflow.
  - cnt increments, wrapping at WINDOW-1 to 0.
- Window close, on q with cnt==WINDOW-1:
  - The final result uses the current sample's contribution.
  - If slot free (res_valid==0, or res_valid&res_ready this cycle): load res_peak/res_ang/res_idx/res_mean and set res_valid=1 next cycle.
  - Otherwise overrun<=1; the new result is dropped and the old result is held unchanged.
  - The next window starts at cnt=0 regardless.
- Output handshake:
  - Transfer happens when res_valid & res_ready.
  - res_* stay stable while res_valid=1.
  - res_valid clears on transfer unless a window closes in the same cycle; in that case the new result loads and res_valid stays 1.
  - The handshake is not gated by ena.
- overrun is cleared by ovr_clr. If ovr_clr and a new overrun occur in the same cycle, set wins.
- res_ready while res_valid=0 has no effect.
- Latency: result visible on the clk edge following the closing q. No combinational paths from inputs to outputs.

Test Plan:
- Fill and find peak: WINDOW=4, LATENCY=17, ena=1. in_valid pulses, rin sequence 100,300,200,50 after latency → res_valid one cycle after the 4th q; res_peak=300, res_idx=1, res_mean=162, res_ang=ain of sample 1. Hold res_ready=0; outputs stay stable.
- Tie and stall: rin 500,500,10,10. Toggle ena=0 for 5 cycles mid-stream (processor inputs frozen) → res_idx=0, res_mean=255. The stall introduces no extra or lost samples.
- Overrun: res_ready=0 over two full windows → first result held, overrun=1 after second window closes. Assert ovr_clr → overrun=0 next cycle; res_* are still the first window's values.
- Simultaneous accept and close: res_ready=1 on the exact cycle the next window closes → res_valid stays 1, new values loaded, overrun stays 0.
- Reset mid-window: rst after 2 of 4 samples, then 4 new samples 7,8,9,6 → result peak=9, idx=2. No contribution from pre-reset samples or from in-flight vpipe entries.
- Gaps: in_valid=1 every third cycle with random rin → result matches a reference model; cnt advances only on q.
